// File: rtl/sprite_cmd_unit.sv
// sprite_cmd_unit
// Executes sprite commands (ACT, LD, RD, MAP, CORD, TM) handed over from EX.
// Owns the sprite attribute table (single-port, synchronous read) and the
// frame-tick timer used by the display.
// Entry layout: [31] active, [30:27] action, [26:19] image, [18:9] x, [8:0] y.

module sprite_cmd_unit #(
    parameter int NUM_SPRITES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    input  logic [2:0]  cmd_op,
    input  logic [7:0]  sprite_addr,
    input  logic [3:0]  sprite_action,
    input  logic [13:0] operand,
    input  logic [4:0]  dst_reg_in,
    output logic        cmd_ready,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic [4:0]  rd_dst,
    output logic        frame_tick
);

    localparam int AW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_SPRITES - 1);

    localparam logic [2:0] OP_ACT  = 3'b000;
    localparam logic [2:0] OP_LD   = 3'b001;
    localparam logic [2:0] OP_RD   = 3'b010;
    localparam logic [2:0] OP_MAP  = 3'b011;
    localparam logic [2:0] OP_CORD = 3'b100;
    localparam logic [2:0] OP_TM   = 3'b101;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'b00,
        ST_IDLE  = 2'b01,
        ST_READ  = 2'b10,
        ST_WRITE = 2'b11
    } state_t;

    state_t         state_r;
    state_t         state_s;

    logic [31:0]    mem_r [0:NUM_SPRITES-1];
    logic [31:0]    mem_q_r;
    logic [AW-1:0]  clr_idx_r;

    logic [AW-1:0]  addr_r;
    logic [2:0]     op_r;
    logic [3:0]     action_r;
    logic [9:0]     operand_r;
    logic [4:0]     dst_r;
    logic [31:0]    wdata_r;

    logic           cmd_ready_r;
    logic           rd_valid_r;
    logic [31:0]    rd_data_r;
    logic [4:0]     rd_dst_r;

    logic [13:0]    period_r;
    logic [13:0]    counter_r;
    logic           tick_r;

    logic           accept_s;
    logic           in_range_s;
    logic           is_read_op_s;
    logic           is_write_op_s;
    logic           issue_s;
    logic           oor_read_s;
    logic           op_r_is_read_s;
    logic [AW-1:0]  addr_idx_s;
    logic [31:0]    modify_s;
    logic [31:0]    cord_s;

    // Range check only exists when the table is shallower than the 8-bit index space
    generate
        if (NUM_SPRITES >= 256) begin : g_full_range
            assign in_range_s = 1'b1;
        end else begin : g_part_range
            assign in_range_s = ({1'b0, sprite_addr} < 9'(NUM_SPRITES));
        end
    endgenerate

    assign addr_idx_s     = sprite_addr[AW-1:0];
    assign accept_s       = cmd_valid & cmd_ready_r;
    assign is_read_op_s   = (cmd_op == OP_RD) || (cmd_op == OP_CORD);
    assign is_write_op_s  = (cmd_op == OP_ACT) || (cmd_op == OP_LD) || (cmd_op == OP_MAP);
    assign issue_s        = accept_s && in_range_s && (is_read_op_s || is_write_op_s);
    assign oor_read_s     = accept_s && !in_range_s && is_read_op_s;
    assign op_r_is_read_s = (op_r == OP_RD) || (op_r == OP_CORD);
    assign cord_s         = {13'd0, mem_q_r[18:9], mem_q_r[8:0]};

    // Next-state logic for the command sequencer
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_idx_r == LAST_IDX) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_CLEAR;
                end
            end
            ST_IDLE: begin
                if (issue_s) begin
                    state_s = ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (op_r_is_read_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WRITE;
                end
            end
            ST_WRITE: state_s = ST_IDLE;
            default:  state_s = ST_CLEAR;
        endcase
    end

    // Read-modify step: patch only the fields named by the latched op
    always_comb begin
        modify_s = mem_q_r;
        case (op_r)
            OP_ACT: begin
                modify_s[31]    = operand_r[0];
                modify_s[30:27] = action_r;
            end
            OP_LD: begin
                modify_s[26:19] = operand_r[7:0];
            end
            OP_MAP: begin
                if (action_r[0]) begin
                    modify_s[8:0] = operand_r[8:0];
                end else begin
                    modify_s[18:9] = operand_r[9:0];
                end
            end
            default: modify_s = mem_q_r;
        endcase
    end

    // Attribute table: clear sweep, write-back, and synchronous read at issue
    always_ff @(posedge clk) begin
        if (state_r == ST_CLEAR) begin
            mem_r[clr_idx_r] <= 32'd0;
        end else if (state_r == ST_WRITE) begin
            mem_r[addr_r] <= wdata_r;
        end else if ((state_r == ST_IDLE) && issue_s) begin
            mem_q_r <= mem_r[addr_idx_s];
        end
    end

    // Sequencer state, clear index and ready flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_CLEAR;
            clr_idx_r   <= '0;
            cmd_ready_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cmd_ready_r <= (state_s == ST_IDLE);
            if (state_r == ST_CLEAR) begin
                clr_idx_r <= clr_idx_r + AW'(1);
            end else begin
                clr_idx_r <= '0;
            end
        end
    end

    // Command fields are captured only when a command is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r    <= '0;
            op_r      <= 3'd0;
            action_r  <= 4'd0;
            operand_r <= 10'd0;
            dst_r     <= 5'd0;
        end else if (accept_s) begin
            addr_r    <= addr_idx_s;
            op_r      <= cmd_op;
            action_r  <= sprite_action;
            operand_r <= operand[9:0];
            dst_r     <= dst_reg_in;
        end
    end

    // Modified entry is staged in READ and written in WRITE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdata_r <= 32'd0;
        end else if (state_r == ST_READ) begin
            wdata_r <= modify_s;
        end
    end

    // Read return: single-cycle valid pulse, data/dst held until the next read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= 32'd0;
            rd_dst_r   <= 5'd0;
        end else if ((state_r == ST_READ) && op_r_is_read_s) begin
            rd_valid_r <= 1'b1;
            rd_data_r  <= (op_r == OP_RD) ? mem_q_r : cord_s;
            rd_dst_r   <= dst_r;
        end else if (oor_read_s) begin
            rd_valid_r <= 1'b1;
            rd_data_r  <= 32'd0;
            rd_dst_r   <= dst_reg_in;
        end else begin
            rd_valid_r <= 1'b0;
        end
    end

    // Frame timer: free-running, independent of the sequencer; TM accept wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_r  <= 14'd0;
            counter_r <= 14'd0;
            tick_r    <= 1'b0;
        end else if (accept_s && (cmd_op == OP_TM)) begin
            period_r  <= operand;
            counter_r <= operand;
            tick_r    <= 1'b0;
        end else if (period_r == 14'd0) begin
            counter_r <= 14'd0;
            tick_r    <= 1'b0;
        end else if (counter_r <= 14'd1) begin
            counter_r <= period_r;
            tick_r    <= 1'b1;
        end else begin
            counter_r <= counter_r - 14'd1;
            tick_r    <= 1'b0;
        end
    end

    assign cmd_ready  = cmd_ready_r;
    assign rd_valid   = rd_valid_r;
    assign rd_data    = rd_data_r;
    assign rd_dst     = rd_dst_r;
    assign frame_tick = tick_r;

endmodule

// File: tb/tb_sprite_cmd_unit.sv
// Directed bench for sprite_cmd_unit: a 256-entry and a 64-entry instance
// share one command bus; 'sel' steers cmd_valid and picks which outputs are observed.

module tb_sprite_cmd_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_op = 3'd0;
    logic [7:0]  sprite_addr = 8'd0;
    logic [3:0]  sprite_action = 4'd0;
    logic [13:0] operand = 14'd0;
    logic [4:0]  dst_reg_in = 5'd0;

    logic        rdy_a, rdv_a, tick_a, rdy_b, rdv_b, tick_b;
    logic [31:0] data_a, data_b;
    logic [4:0]  dst_a, dst_b;
    logic        valid_a, valid_b;
    logic        rdy_m, rdv_m, tick_m;
    logic [31:0] data_m;
    logic [4:0]  dst_m;

    int checks = 0;
    int errors = 0;

    assign valid_a = cmd_valid & ~sel;
    assign valid_b = cmd_valid & sel;
    assign rdy_m   = sel ? rdy_b  : rdy_a;
    assign rdv_m   = sel ? rdv_b  : rdv_a;
    assign tick_m  = sel ? tick_b : tick_a;
    assign data_m  = sel ? data_b : data_a;
    assign dst_m   = sel ? dst_b  : dst_a;

    sprite_cmd_unit #(.NUM_SPRITES(256)) u_dut256 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(valid_a), .cmd_op(cmd_op),
        .sprite_addr(sprite_addr), .sprite_action(sprite_action), .operand(operand),
        .dst_reg_in(dst_reg_in), .cmd_ready(rdy_a), .rd_valid(rdv_a),
        .rd_data(data_a), .rd_dst(dst_a), .frame_tick(tick_a)
    );

    sprite_cmd_unit #(.NUM_SPRITES(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(valid_b), .cmd_op(cmd_op),
        .sprite_addr(sprite_addr), .sprite_action(sprite_action), .operand(operand),
        .dst_reg_in(dst_reg_in), .cmd_ready(rdy_b), .rd_valid(rdv_b),
        .rd_data(data_b), .rd_dst(dst_b), .frame_tick(tick_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic [2:0]  op;
        logic [7:0]  addr;
        logic [3:0]  act;
        logic [13:0] opnd;
        logic [4:0]  dst;
        int          exp_busy;   // cycles with cmd_ready low after accept
        int          exp_rd_k;   // cycle index of rd_valid after accept, -1 = none
        logic [31:0] exp_data;
        logic [4:0]  exp_dst;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs[NV];

    function automatic vec_t mkv(logic s, logic [2:0] op, logic [7:0] a, logic [3:0] ac,
                                 logic [13:0] o, logic [4:0] d, int b, int k,
                                 logic [31:0] ed, logic [4:0] edst);
        vec_t v;
        v.sel = s; v.op = op; v.addr = a; v.act = ac; v.opnd = o; v.dst = d;
        v.exp_busy = b; v.exp_rd_k = k; v.exp_data = ed; v.exp_dst = edst;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Wait for cmd_ready, present one command for exactly one accepting edge.
    // Returns at accept edge + 1 time unit; waited = idle cycles spent held off.
    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [3:0] ac,
                        input logic [13:0] o, input logic [4:0] d, output int waited);
        int n;
        n = 0;
        @(negedge clk);
        while (!rdy_m && n < 1000) begin
            @(negedge clk);
            n++;
        end
        waited = n;
        if (n >= 1000) begin
            check("send_timeout", 32'(n), 32'd0);
        end else begin
            cmd_op = op; sprite_addr = a; sprite_action = ac; operand = o; dst_reg_in = d;
            cmd_valid = 1'b1;
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int w, busy, rd_cnt, rd_first;
        busy = 0; rd_cnt = 0; rd_first = -1;
        sel = v.sel;
        send(v.op, v.addr, v.act, v.opnd, v.dst, w);
        for (int k = 0; k < 4; k++) begin
            if (!rdy_m) busy++;
            if (rdv_m) begin
                rd_cnt++;
                if (rd_first < 0) rd_first = k;
            end
            @(posedge clk);
            #1;
        end
        check($sformatf("v%0d_busy", idx), 32'(busy), 32'(v.exp_busy));
        if (v.exp_rd_k < 0) begin
            check($sformatf("v%0d_no_rdvalid", idx), 32'(rd_cnt), 32'd0);
        end else begin
            check($sformatf("v%0d_rdvalid_pulses", idx), 32'(rd_cnt), 32'd1);
            check($sformatf("v%0d_latency", idx), 32'(rd_first), 32'(v.exp_rd_k));
            check($sformatf("v%0d_rd_data", idx), data_m, v.exp_data);
            check($sformatf("v%0d_rd_dst", idx), 32'(dst_m), 32'(v.exp_dst));
        end
    endtask

    // Count edges after reset release until each instance raises cmd_ready
    task automatic count_clear(output int na, output int nb, output int nrd);
        na = 0; nb = 0; nrd = 0;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            #1;
            if (rdy_a && na == 0) na = n;
            if (rdy_b && nb == 0) nb = n;
            if (rdv_a || rdv_b) nrd++;
            if (na != 0 && nb != 0) break;
        end
    endtask

    // Sample frame_tick for 'len' cycles starting at the current point; expect
    // a tick at every positive multiple of 'per' (per = 0: never)
    task automatic watch_ticks(input string name, input int len, input int per);
        logic exp;
        for (int k = 0; k < len; k++) begin
            exp = (per != 0) && (k != 0) && ((k % per) == 0);
            check($sformatf("%s_k%0d", name, k), 32'(tick_m), 32'(exp));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int na, nb, nrd, w, busy_lo;
        logic seen;

        vecs[0]  = mkv(0, 3'b010,   0, 4'h0, 14'h0000,  1, 1,  1, 32'h0000_0000,  1);
        vecs[1]  = mkv(0, 3'b010, 128, 4'h0, 14'h0000,  2, 1,  1, 32'h0000_0000,  2);
        vecs[2]  = mkv(0, 3'b010, 255, 4'h0, 14'h0000,  3, 1,  1, 32'h0000_0000,  3);
        vecs[3]  = mkv(0, 3'b000,   5, 4'hA, 14'h0001,  0, 2, -1, 32'h0,          0);
        vecs[4]  = mkv(0, 3'b001,   5, 4'h0, 14'h003C,  0, 2, -1, 32'h0,          0);
        vecs[5]  = mkv(0, 3'b010,   5, 4'h0, 14'h0000,  7, 1,  1, 32'hD1E0_0000,  7);
        vecs[6]  = mkv(0, 3'b011,   9, 4'h0, 14'd640,   0, 2, -1, 32'h0,          0);
        vecs[7]  = mkv(0, 3'b011,   9, 4'h1, 14'd479,   0, 2, -1, 32'h0,          0);
        vecs[8]  = mkv(0, 3'b100,   9, 4'h0, 14'h0000, 12, 1,  1, 32'h0005_01DF, 12);
        vecs[9]  = mkv(0, 3'b010,   9, 4'h0, 14'h0000, 13, 1,  1, 32'h0005_01DF, 13);
        vecs[10] = mkv(0, 3'b011,   5, 4'h1, 14'h2005,  0, 2, -1, 32'h0,          0);
        vecs[11] = mkv(0, 3'b000,   5, 4'h3, 14'h3FFE,  0, 2, -1, 32'h0,          0);
        vecs[12] = mkv(0, 3'b010,   5, 4'h0, 14'h0000, 31, 1,  1, 32'h19E0_0005, 31);
        vecs[13] = mkv(0, 3'b011,   9, 4'h0, 14'h3FFF,  0, 2, -1, 32'h0,          0);
        vecs[14] = mkv(0, 3'b100,   9, 4'h0, 14'h0000,  4, 1,  1, 32'h0007_FFDF,  4);
        vecs[15] = mkv(0, 3'b110,   5, 4'hF, 14'h3FFF,  8, 0, -1, 32'h0,          0);
        vecs[16] = mkv(0, 3'b111,   5, 4'hF, 14'h3FFF,  8, 0, -1, 32'h0,          0);
        vecs[17] = mkv(0, 3'b010,   5, 4'h0, 14'h0000,  9, 1,  1, 32'h19E0_0005,  9);
        vecs[18] = mkv(1, 3'b001,   8, 4'h0, 14'h00FF,  0, 2, -1, 32'h0,          0);
        vecs[19] = mkv(1, 3'b010,   8, 4'h0, 14'h0000,  6, 1,  1, 32'h07F8_0000,  6);
        vecs[20] = mkv(1, 3'b001, 200, 4'h0, 14'h0055,  0, 0, -1, 32'h0,          0);
        vecs[21] = mkv(1, 3'b010, 200, 4'h0, 14'h0000, 10, 0,  0, 32'h0000_0000, 10);
        vecs[22] = mkv(1, 3'b010,   8, 4'h0, 14'h0000, 11, 1,  1, 32'h07F8_0000, 11);
        vecs[23] = mkv(1, 3'b100, 100, 4'h0, 14'h0000, 14, 0,  0, 32'h0000_0000, 14);
        vecs[24] = mkv(1, 3'b000, 255, 4'hF, 14'h0001,  0, 0, -1, 32'h0,          0);
        vecs[25] = mkv(1, 3'b011,  64, 4'h0, 14'h0001,  0, 0, -1, 32'h0,          0);
        vecs[26] = mkv(1, 3'b010,  63, 4'h0, 14'h0000, 15, 1,  1, 32'h0000_0000, 15);

        // Reset state on both instances
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'({rdy_a, rdy_b}), 32'd0);
        check("rst_rd_valid",  32'({rdv_a, rdv_b}), 32'd0);
        check("rst_rd_data",   data_a | data_b, 32'd0);
        check("rst_rd_dst",    32'({dst_a, dst_b}), 32'd0);
        check("rst_frame_tick", 32'({tick_a, tick_b}), 32'd0);

        // Clear sweep lengths
        @(negedge clk);
        rst_n = 1'b1;
        count_clear(na, nb, nrd);
        check("clear_cycles_256", 32'(na), 32'd256);
        check("clear_cycles_64",  32'(nb), 32'd64);
        check("clear_no_rdvalid", 32'(nrd), 32'd0);

        // Table-driven command vectors
        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], i);
        end

        // Back-to-back: read right after a write to the same entry
        sel = 1'b0;
        send(3'b001, 8'd5, 4'h0, 14'h0011, 5'd0, w);
        send(3'b010, 8'd5, 4'h0, 14'h0000, 5'd21, w);
        check("b2b_holdoff", 32'(w), 32'd2);
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            if (rdv_m) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("b2b_rd_seen", 32'(seen), 32'd1);
        check("b2b_rd_data", data_m, 32'h1888_0005);
        check("b2b_rd_dst",  32'(dst_m), 32'd21);

        // Timer: period 4, then disable mid-count
        send(3'b101, 8'd0, 4'h0, 14'd4, 5'd0, w);
        watch_ticks("tm4", 17, 4);
        send(3'b101, 8'd0, 4'h0, 14'd0, 5'd0, w);
        watch_ticks("tm0", 12, 0);

        // TM held off behind a write, then programmed with period 3
        send(3'b000, 8'd30, 4'h1, 14'h0001, 5'd0, w);
        send(3'b101, 8'd0, 4'h0, 14'd3, 5'd0, w);
        check("tm_holdoff_cycles", 32'(w), 32'd2);
        watch_ticks("tm3", 10, 3);
        send(3'b101, 8'd0, 4'h0, 14'd0, 5'd0, w);
        watch_ticks("tm3_off", 6, 0);

        // Reset during the WRITE of an ACT
        run_vec(mkv(0, 3'b000, 20, 4'hF, 14'h0001, 0, 2, -1, 32'h0, 0), 100);
        run_vec(mkv(0, 3'b010, 20, 4'h0, 14'h0000, 2, 1, 1, 32'hF800_0000, 2), 101);
        send(3'b000, 8'd20, 4'h0, 14'h0000, 5'd0, w);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        busy_lo = 0;
        for (int k = 0; k < 3; k++) begin
            if (rdv_a || rdy_a) busy_lo++;
            @(negedge clk);
        end
        check("midrst_outputs_quiet", 32'(busy_lo), 32'd0);
        rst_n = 1'b1;
        count_clear(na, nb, nrd);
        check("midrst_clear_256", 32'(na), 32'd256);
        check("midrst_clear_64",  32'(nb), 32'd64);
        check("midrst_no_rdvalid", 32'(nrd), 32'd0);
        run_vec(mkv(0, 3'b010, 20, 4'h0, 14'h0000, 17, 1, 1, 32'h0, 17), 102);
        run_vec(mkv(0, 3'b010,  5, 4'h0, 14'h0000, 18, 1, 1, 32'h0, 18), 103);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
